// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, micro-step encoding and seven-segment table for the teaching CPU
package cpu_pkg;

    // Instruction opcodes (instruction bits [7:4]); 0x8..0xD decode as NOPs
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_LDI = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JC  = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Micro-steps; every instruction walks T0..T4 and wraps back to T0
    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    // Active-low segment patterns, bit 0 = a ... bit 6 = g
    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_mux.sv
// rtl/seg7_mux.sv - time-multiplexed 8-digit seven-segment driver
module seg7_mux
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] digits,
    input  logic [7:0]  en,
    output logic [7:0]  an,
    output logic [6:0]  c
);

    logic [16:0] refresh_cnt;
    logic [2:0]  sel;
    logic [3:0]  nibble;

    assign sel    = refresh_cnt[16:14];
    assign nibble = digits[{sel, 2'b00} +: 4];

    // Free-running refresh counter; its top three bits pick the active digit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 17'd1;
        end
    end

    // Drive one anode low for an enabled digit; disabled digits stay dark
    always_comb begin
        an = 8'hFF;
        c  = SEG_BLANK;
        if (en[sel]) begin
            an = ~(8'b0000_0001 << sel);
            c  = hex_to_seg(nibble);
        end
    end

endmodule

// File: rtl/cpu_top_core.sv
// rtl/cpu_top_core.sv - board top of the 8-bit SAP-style teaching CPU
module cpu_top_core
    import cpu_pkg::*;
#(
    parameter int CLOCK_DIV = 50_000_000
) (
    input  logic        CLK100MHZ,
    input  logic [15:0] SW,
    output logic [15:0] LED,
    output logic [6:0]  C,
    output logic [7:0]  AN,
    output logic        DP
);

    localparam int DW = (CLOCK_DIV > 2) ? $clog2(CLOCK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLOCK_DIV - 1);

    logic rst_n;
    logic run;
    logic hold;
    logic unused_sw;

    assign rst_n     = ~SW[1];
    assign run       = SW[0];
    assign hold      = SW[2];
    assign unused_sw = ^SW[15:3];

    // CPU state
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic          advance;
    logic [3:0]    pc;
    logic [3:0]    mar;
    logic [7:0]    ir;
    logic [7:0]    a;
    logic [7:0]    b;
    logic [7:0]    out_reg;
    logic          cf;
    logic          zf;
    logic          halted;
    step_t         step;

    logic [3:0]    op;
    logic [7:0]    ram_rd;
    logic [8:0]    alu_sum;

    // Program/data RAM with the built-in default program; reset does not touch it
    logic [7:0] ram [0:15] = '{
        8'h0E, 8'h1F, 8'hE0, 8'hF0,
        8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h1C, 8'h0E
    };

    assign op      = ir[7:4];
    assign ram_rd  = ram[mar];
    assign tick    = run && (div_cnt == DIV_LAST);
    assign advance = tick && !halted && !hold;

    // Divider: counts only while run is on, so pausing keeps the phase
    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (run) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    // Adder shared by ADD and SUB; SUB adds the two's complement of B
    always_comb begin
        if (op == OP_SUB) begin
            alu_sum = {1'b0, a} + {1'b0, ~b} + 9'd1;
        end else begin
            alu_sum = {1'b0, a} + {1'b0, b};
        end
    end

    // STA stores the accumulator at T3
    always_ff @(posedge CLK100MHZ) begin
        if (rst_n && advance && (step == T3) && (op == OP_STA)) begin
            ram[mar] <= a;
        end
    end

    // Micro-coded sequencer: fetch in T0/T1, opcode-specific work in T2..T4
    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) begin
            step    <= T0;
            pc      <= '0;
            mar     <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            out_reg <= '0;
            cf      <= 1'b0;
            zf      <= 1'b0;
            halted  <= 1'b0;
        end else if (advance) begin
            case (step)
                T0: begin
                    mar  <= pc;
                    step <= T1;
                end
                T1: begin
                    ir   <= ram_rd;
                    pc   <= pc + 4'd1;
                    step <= T2;
                end
                T2: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: mar <= ir[3:0];
                        OP_LDI: a <= {4'h0, ir[3:0]};
                        OP_JMP: pc <= ir[3:0];
                        OP_JC:  if (cf) pc <= ir[3:0];
                        OP_JZ:  if (zf) pc <= ir[3:0];
                        OP_OUT: out_reg <= a;
                        OP_HLT: halted <= 1'b1;
                        default: ;
                    endcase
                    step <= T3;
                end
                T3: begin
                    case (op)
                        OP_LDA:         a <= ram_rd;
                        OP_ADD, OP_SUB: b <= ram_rd;
                        default: ;
                    endcase
                    step <= T4;
                end
                T4: begin
                    if ((op == OP_ADD) || (op == OP_SUB)) begin
                        a  <= alu_sum[7:0];
                        cf <= alu_sum[8];
                        zf <= (alu_sum[7:0] == 8'h00);
                    end
                    step <= T0;
                end
                default: step <= T0;
            endcase
        end
    end

    assign LED = {halted, step, pc, out_reg};
    assign DP  = 1'b1;

    seg7_mux u_seg (
        .clk    (CLK100MHZ),
        .rst_n  (rst_n),
        .digits ({12'h000, pc, 8'h00, out_reg}),
        .en     (8'b0001_0011),
        .an     (AN),
        .c      (C)
    );

endmodule

// File: tb/tb_cpu_top_core.sv
// tb/tb_cpu_top_core.sv - directed self-checking bench for cpu_top_core
module tb_cpu_top_core;

    logic        clk = 1'b0;
    logic [15:0] sw  = 16'h0002;
    logic [15:0] led;
    logic [6:0]  c;
    logic [7:0]  an;
    logic        dp;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] an;
        logic [6:0] c;
        logic       chk_c;
    } disp_vec_t;

    disp_vec_t vecs [8];

    cpu_top_core #(.CLOCK_DIV(10)) dut (
        .CLK100MHZ (clk),
        .SW        (sw),
        .LED       (led),
        .C         (c),
        .AN        (an),
        .DP        (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        sw = 16'h0002;
        @(negedge clk);
        sw = 16'h0000;
    endtask

    task automatic wait_halt(input string name, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (led[15]) found = 1'b1;
        end
        chk(name, {31'd0, found}, 32'd1);
    endtask

    initial begin
        logic found;

        vecs[0] = '{3'd0, 8'hFE, 7'h08, 1'b1};
        vecs[1] = '{3'd1, 8'hFD, 7'h24, 1'b1};
        vecs[2] = '{3'd2, 8'hFF, 7'h7F, 1'b0};
        vecs[3] = '{3'd3, 8'hFF, 7'h7F, 1'b0};
        vecs[4] = '{3'd4, 8'hEF, 7'h19, 1'b1};
        vecs[5] = '{3'd5, 8'hFF, 7'h7F, 1'b0};
        vecs[6] = '{3'd6, 8'hFF, 7'h7F, 1'b0};
        vecs[7] = '{3'd7, 8'hFF, 7'h7F, 1'b0};

        // Reset state
        repeat (5) @(negedge clk);
        sw = 16'h0000;
        @(negedge clk);
        chk("reset_led", {16'd0, led}, 32'h0000);
        chk("reset_an", {24'd0, an}, 32'hFE);
        chk("reset_c", {25'd0, c}, 32'h40);
        chk("reset_dp", {31'd0, dp}, 32'd1);

        // Default program with exact tick timing
        sw = 16'h0001;
        for (int cyc = 1; cyc <= 180; cyc++) begin
            @(negedge clk);
            if (cyc == 9)   chk("step_before_first_tick", {29'd0, led[14:12]}, 32'd0);
            if (cyc == 10)  chk("step_after_first_tick", {29'd0, led[14:12]}, 32'd1);
            if (cyc == 179) chk("halted_before_tick18", {31'd0, led[15]}, 32'd0);
            if (cyc == 180) chk("halted_at_tick18", {31'd0, led[15]}, 32'd1);
        end
        chk("default_final_led", {16'd0, led}, 32'hB42A);
        repeat (500) @(negedge clk);
        chk("default_frozen_led", {16'd0, led}, 32'hB42A);

        // Display digit selection with OUT=0x2A, PC=4
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            dut.u_seg.refresh_cnt = {vecs[i].sel, 14'd0};
            #1;
            chk($sformatf("disp_an_sel%0d", i), {24'd0, an}, {24'd0, vecs[i].an});
            if (vecs[i].chk_c) chk($sformatf("disp_c_sel%0d", i), {25'd0, c}, {25'd0, vecs[i].c});
            chk($sformatf("disp_dp_sel%0d", i), {31'd0, dp}, 32'd1);
        end

        // Manual halt at T2 of ADD, then resume
        do_reset();
        chk("reset_after_halt_led", {16'd0, led}, 32'h0000);
        sw = 16'h0001;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (led[11:8] == 4'd2 && led[14:12] == 3'd2) found = 1'b1;
        end
        chk("reach_add_t2", {31'd0, found}, 32'd1);
        sw = 16'h0005;
        repeat (100) @(negedge clk);
        chk("manual_halt_frozen", {16'd0, led}, 32'h2200);
        sw = 16'h0001;
        wait_halt("manual_resume_halt", 300);
        chk("manual_resume_led", {16'd0, led}, 32'hB42A);

        // Reset mid-instruction, then run enable off
        do_reset();
        sw = 16'h0001;
        repeat (73) @(negedge clk);
        sw = 16'h0003;
        @(negedge clk);
        chk("mid_reset_led", {16'd0, led}, 32'h0000);
        sw = 16'h0000;
        repeat (200) @(negedge clk);
        chk("run_off_led", {16'd0, led}, 32'h0000);

        // Subtraction to zero: flags set and JZ taken
        sw = 16'h0002;
        @(negedge clk);
        for (int i = 0; i < 16; i++) dut.ram[i] = 8'h00;
        dut.ram[0]  = 8'h45;
        dut.ram[1]  = 8'h2E;
        dut.ram[2]  = 8'h76;
        dut.ram[3]  = 8'h47;
        dut.ram[4]  = 8'hE0;
        dut.ram[5]  = 8'hF0;
        dut.ram[6]  = 8'hE0;
        dut.ram[7]  = 8'hF0;
        dut.ram[14] = 8'h05;
        sw = 16'h0001;
        wait_halt("sub_halt", 500);
        chk("sub_led", {16'd0, led}, 32'hB800);
        chk("sub_zf", {31'd0, dut.zf}, 32'd1);
        chk("sub_cf", {31'd0, dut.cf}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
